// File: rtl/route_pkg.sv
// Shared types and constants for the route sequencer: FSM state encoding,
// the default terminating code and the actuator's directional move codes.
package route_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD    = 3'd2,
    S_PRESENT = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [3:0] END_CODE_DEF = 4'b0000;

  // One-hot direction bits; diagonal moves combine two of them.
  localparam logic [3:0] MOVE_FWD   = 4'b0001;
  localparam logic [3:0] MOVE_BACK  = 4'b0010;
  localparam logic [3:0] MOVE_LEFT  = 4'b0100;
  localparam logic [3:0] MOVE_RIGHT = 4'b1000;

endpackage

// File: rtl/dwell_timer.sv
// 32-bit dwell counter: held at 0 while clr, counts while en, expire when count == HOLD_CYCLES-1.
// Expire is combinational from the count register; no backpressure.
module dwell_timer #(
  parameter logic [31:0] HOLD_CYCLES = 32'd50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 32'd0;
    end else if (en) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == (HOLD_CYCLES - 32'd1));

endmodule

// File: rtl/route_sequencer.sv
// Walks route RAM 0..last, offers each code on valid/ready, dwells HOLD_CYCLES after acceptance.
// start->first move_valid: 3 cycles; move/move_valid hold steady while move_ready is low.
module route_sequencer
  import route_pkg::*;
#(
  parameter logic [31:0] HOLD_CYCLES = 32'd50000000,
  parameter logic [3:0]  END_CODE    = END_CODE_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] last_addr,
  output logic [3:0] ram_addr,
  input  logic [3:0] ram_q,
  output logic [3:0] move,
  output logic       move_valid,
  input  logic       move_ready,
  output logic [3:0] step,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  logic [3:0] step_q;
  logic [3:0] last_q;
  logic [3:0] move_q;
  logic       move_valid_q;
  logic       busy_q;
  logic       done_q;

  logic hold_en;
  logic hold_clr;
  logic hold_expire;

  // Counter runs only in HOLD and sits at zero otherwise, so HOLD always starts from 0.
  assign hold_en  = (state_q == S_HOLD);
  assign hold_clr = !hold_en;

  dwell_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (hold_clr),
    .en     (hold_en),
    .expire (hold_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      step_q       <= 4'd0;
      last_q       <= 4'd0;
      move_q       <= 4'd0;
      move_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // A handshake coinciding with abort counts as taken, but no dwell follows.
        if (state_q != S_IDLE) begin
          state_q      <= S_IDLE;
          step_q       <= 4'd0;
          move_q       <= 4'd0;
          move_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              last_q  <= last_addr;
              step_q  <= 4'd0;
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            state_q <= S_LOAD;
          end
          S_LOAD: begin
            move_q <= ram_q;
            if (ram_q == END_CODE) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              move_valid_q <= 1'b1;
              state_q      <= S_PRESENT;
            end
          end
          S_PRESENT: begin
            if (move_ready) begin
              move_valid_q <= 1'b0;
              state_q      <= S_HOLD;
            end
          end
          S_HOLD: begin
            // The last-step check precedes the increment, so step never wraps.
            if (hold_expire) begin
              if (step_q == last_q) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                step_q  <= step_q + 4'd1;
                state_q <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            move_q  <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            state_q      <= S_IDLE;
            move_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ram_addr   = step_q;
  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
